// File: rtl/cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : cpu_top (with cpu_imem, cpu_regfile, cpu_ctrl)
// Brief    : Multi-cycle 16-bit accumulator-style CPU, 4 GPRs, 8-bit memories.
//            Optional macro LDI_SIGN_EXT_EN sign-extends imm for LDI/JMP/JZ.
// Revision : 1.0 - initial release
// ============================================================================

module cpu_imem #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        i_we,
  input  logic [7:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata
);
  logic [15:0] memory [0:IMEM_DEPTH-1];

  // In-system program load port; normally tied off and preloaded externally
  always_ff @(posedge clk) begin
    if (i_we) memory[i_addr] <= i_wdata;
  end

  assign o_rdata = memory[i_addr];
endmodule

module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [1:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_raddr_a,
  input  logic [1:0]  i_raddr_b,
  output logic [15:0] o_rdata_a,
  output logic [15:0] o_rdata_b
);
  logic [15:0] registers [0:3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) registers[i] <= '0;
    end else if (i_we) begin
      registers[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = registers[i_raddr_a];
  assign o_rdata_b = registers[i_raddr_b];
endmodule

module cpu_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_opcode,
  output logic       o_fetch,
  output logic       o_execute,
  output logic       o_memory,
  output logic       o_writeback,
  output logic       o_halt
);
  localparam logic [3:0] C_OP_NOP = 4'h0;
  localparam logic [3:0] C_OP_LD  = 4'hA;
  localparam logic [3:0] C_OP_ST  = 4'hB;
  localparam logic [3:0] C_OP_JMP = 4'hC;
  localparam logic [3:0] C_OP_JZ  = 4'hD;
  localparam logic [3:0] C_OP_HLT = 4'hE;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  state_t state;
  state_t w_next_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= w_next_state;
  end

  always_comb begin
    w_next_state = FETCH;
    o_fetch      = 1'b0;
    o_execute    = 1'b0;
    o_memory     = 1'b0;
    o_writeback  = 1'b0;
    o_halt       = 1'b0;
    case (state)
      FETCH: begin
        o_fetch      = 1'b1;
        w_next_state = DECODE;
      end
      DECODE: w_next_state = (i_opcode == C_OP_HLT) ? HALT : EXECUTE;
      EXECUTE: begin
        o_execute = 1'b1;
        case (i_opcode)
          C_OP_NOP, C_OP_JMP, C_OP_JZ: w_next_state = FETCH;
          C_OP_LD, C_OP_ST:            w_next_state = MEMORY;
          C_OP_HLT:                    w_next_state = HALT;
          default:                     w_next_state = WRITEBACK;
        endcase
      end
      MEMORY: begin
        o_memory     = 1'b1;
        w_next_state = (i_opcode == C_OP_LD) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        o_writeback  = 1'b1;
        w_next_state = FETCH;
      end
      HALT: begin
        o_halt       = 1'b1;
        w_next_state = HALT;
      end
      default: w_next_state = FETCH;
    endcase
  end
endmodule

module cpu_top #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic        halt,
  output logic [15:0] pc_out,
  output logic [15:0] alu_result
);
  localparam logic [3:0] C_OP_ADD = 4'h1;
  localparam logic [3:0] C_OP_SUB = 4'h2;
  localparam logic [3:0] C_OP_AND = 4'h3;
  localparam logic [3:0] C_OP_OR  = 4'h4;
  localparam logic [3:0] C_OP_XOR = 4'h5;
  localparam logic [3:0] C_OP_NOT = 4'h6;
  localparam logic [3:0] C_OP_SHL = 4'h7;
  localparam logic [3:0] C_OP_SHR = 4'h8;
  localparam logic [3:0] C_OP_LDI = 4'h9;
  localparam logic [3:0] C_OP_LD  = 4'hA;
  localparam logic [3:0] C_OP_ST  = 4'hB;
  localparam logic [3:0] C_OP_JMP = 4'hC;
  localparam logic [3:0] C_OP_JZ  = 4'hD;
  localparam logic [3:0] C_OP_MOV = 4'hF;

  logic [15:0] r_pc;
  logic [15:0] instruction_reg;
  logic [15:0] r_mem_data;
  logic        zero_flag;
  logic [15:0] dmem [0:DMEM_DEPTH-1];

  logic [3:0]  w_opcode;
  logic [1:0]  w_rd;
  logic [1:0]  rs;
  logic [7:0]  w_imm;
  logic [15:0] w_imm_ext;
  logic [15:0] w_imem_rdata;
  logic [15:0] w_rd_val;
  logic [15:0] w_rs_val;
  logic [15:0] w_result;
  logic [15:0] w_wb_data;
  logic        w_writes_result;
  logic        w_sets_flag;
  logic        w_fetch;
  logic        w_execute;
  logic        w_memory;
  logic        w_writeback;
  logic        w_halt;

  assign w_opcode = instruction_reg[15:12];
  assign w_rd     = instruction_reg[11:10];
  assign rs       = instruction_reg[9:8];
  assign w_imm    = instruction_reg[7:0];

`ifdef LDI_SIGN_EXT_EN
  assign w_imm_ext = {{8{w_imm[7]}}, w_imm};
`else
  assign w_imm_ext = {8'h00, w_imm};
`endif

  cpu_imem #(.IMEM_DEPTH(IMEM_DEPTH)) imem_inst (
    .clk     (clk),
    .i_we    (1'b0),
    .i_addr  (r_pc[7:0]),
    .i_wdata (16'h0000),
    .o_rdata (w_imem_rdata)
  );

  cpu_regfile regfile_inst (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_writeback),
    .i_waddr   (w_rd),
    .i_wdata   (w_wb_data),
    .i_raddr_a (w_rd),
    .i_raddr_b (rs),
    .o_rdata_a (w_rd_val),
    .o_rdata_b (w_rs_val)
  );

  cpu_ctrl ctrl_inst (
    .clk         (clk),
    .reset       (reset),
    .i_opcode    (w_opcode),
    .o_fetch     (w_fetch),
    .o_execute   (w_execute),
    .o_memory    (w_memory),
    .o_writeback (w_writeback),
    .o_halt      (w_halt)
  );

  always_comb begin
    w_result = '0;
    case (w_opcode)
      C_OP_ADD: w_result = w_rd_val + w_rs_val;
      C_OP_SUB: w_result = w_rd_val - w_rs_val;
      C_OP_AND: w_result = w_rd_val & w_rs_val;
      C_OP_OR:  w_result = w_rd_val | w_rs_val;
      C_OP_XOR: w_result = w_rd_val ^ w_rs_val;
      C_OP_NOT: w_result = ~w_rd_val;
      C_OP_SHL: w_result = {w_rd_val[14:0], 1'b0};
      C_OP_SHR: w_result = {1'b0, w_rd_val[15:1]};
      C_OP_LDI: w_result = w_imm_ext;
      C_OP_MOV: w_result = w_rs_val;
      default:  w_result = '0;
    endcase
  end

  assign w_sets_flag     = (w_opcode >= C_OP_ADD) && (w_opcode <= C_OP_SHR);
  assign w_writes_result = w_sets_flag || (w_opcode == C_OP_LDI) || (w_opcode == C_OP_MOV);
  // Only LD and result-producing ops reach WRITEBACK
  assign w_wb_data       = (w_opcode == C_OP_LD) ? r_mem_data : alu_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc            <= '0;
      instruction_reg <= '0;
      zero_flag       <= 1'b0;
      alu_result      <= '0;
      r_mem_data      <= '0;
    end else begin
      if (w_fetch) begin
        instruction_reg <= w_imem_rdata;
        r_pc            <= r_pc + 16'd1;
      end
      if (w_execute) begin
        if (w_writes_result) alu_result <= w_result;
        if (w_sets_flag)     zero_flag  <= (w_result == 16'h0000);
        if ((w_opcode == C_OP_JMP) || ((w_opcode == C_OP_JZ) && zero_flag))
          r_pc <= w_imm_ext;
      end
      if (w_memory && (w_opcode == C_OP_LD)) r_mem_data <= dmem[w_rs_val[7:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_memory && (w_opcode == C_OP_ST)) dmem[w_rs_val[7:0]] <= w_rd_val;
  end

  assign halt   = w_halt;
  assign pc_out = r_pc;
endmodule
`default_nettype wire

// File: tb/tb_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_top
// Brief    : Directed and randomized programs for cpu_top, checked against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cpu_top;
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        halt;
  logic [15:0] pc_out;
  logic [15:0] alu_result;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prog   [0:255];
  logic [15:0] m_reg  [0:3];
  logic [15:0] m_dmem [0:255];
  logic        m_zf;
  logic [15:0] m_alu;
  logic [15:0] m_pc;
  int          m_cyc;
  int          cyc;
  int          mem_visits;

  cpu_top dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .pc_out     (pc_out),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ext(input logic [7:0] imm);
`ifdef LDI_SIGN_EXT_EN
    return {{8{imm[7]}}, imm};
`else
    return {8'h00, imm};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hE000;
  endtask

  // Holds reset, loads the program and zeroed data memory, releases reset mid-cycle
  task automatic do_reset();
    reset = 1'b0;
    #2;
    for (int i = 0; i < 256; i++) begin
      dut.imem_inst.memory[i] = prog[i];
      dut.dmem[i]             = 16'h0000;
      m_dmem[i]               = 16'h0000;
    end
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
    m_zf  = 1'b0;
    m_alu = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int limit);
    cyc        = 0;
    mem_visits = 0;
    while (!halt && cyc < limit) begin
      tick();
      cyc++;
      if (dut.ctrl_inst.state == 3'd3) mem_visits++;
    end
  endtask

  // ISA-level model: executes whole instructions and accumulates their cycle cost
  task automatic model_run();
    logic [15:0] pc;
    logic [15:0] ins, a, b, r;
    logic [3:0]  op;
    logic [1:0]  d, s;
    pc    = 16'h0000;
    m_cyc = 0;
    for (int step = 0; step < 2000; step++) begin
      ins = prog[pc[7:0]];
      pc  = pc + 16'd1;
      op  = ins[15:12];
      d   = ins[11:10];
      s   = ins[9:8];
      a   = m_reg[d];
      b   = m_reg[s];
      if (op == 4'hE) begin
        m_cyc += 2;
        break;
      end
      case (op)
        4'h0: m_cyc += 3;
        4'hC: begin pc = ext(ins[7:0]); m_cyc += 3; end
        4'hD: begin if (m_zf) pc = ext(ins[7:0]); m_cyc += 3; end
        4'hA: begin m_reg[d] = m_dmem[b[7:0]]; m_cyc += 5; end
        4'hB: begin m_dmem[b[7:0]] = a; m_cyc += 4; end
        default: begin
          case (op)
            4'h1:    r = a + b;
            4'h2:    r = a - b;
            4'h3:    r = a & b;
            4'h4:    r = a | b;
            4'h5:    r = a ^ b;
            4'h6:    r = ~a;
            4'h7:    r = a << 1;
            4'h8:    r = a >> 1;
            4'h9:    r = ext(ins[7:0]);
            default: r = b;
          endcase
          m_reg[d] = r;
          m_alu    = r;
          if (op >= 4'h1 && op <= 4'h8) m_zf = (r == 16'h0000);
          m_cyc += 4;
        end
      endcase
    end
    m_pc = pc;
  endtask

  task automatic compare_model(input string tag);
    int sum_dut, sum_mod;
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.r%0d", tag, i), dut.regfile_inst.registers[i], m_reg[i]);
    check({tag, ".alu"},    alu_result,    m_alu);
    check({tag, ".zf"},     dut.zero_flag, m_zf);
    check({tag, ".pc"},     pc_out,        m_pc);
    check({tag, ".halt"},   halt,          1'b1);
    check({tag, ".cycles"}, cyc,           m_cyc);
    sum_dut = 0;
    sum_mod = 0;
    for (int i = 0; i < 256; i++) begin
      sum_dut += int'(dut.dmem[i]) * (i + 1);
      sum_mod += int'(m_dmem[i]) * (i + 1);
    end
    check({tag, ".dmem"}, sum_dut, sum_mod);
  endtask

  initial begin
    logic [15:0] pc_hold;
    int bad;
    logic [3:0] op;
    int idx;

    // Reset values while reset is held
    #1 reset = 1'b0;
    #12;
    check("rst.pc",    pc_out,                         16'h0000);
    check("rst.halt",  halt,                           1'b0);
    check("rst.alu",   alu_result,                     16'h0000);
    check("rst.state", dut.ctrl_inst.state,            3'd0);
    check("rst.ir",    dut.instruction_reg,            16'h0000);
    check("rst.r2",    dut.regfile_inst.registers[2],  16'h0000);

    // LDI R0,5; LDI R1,3; ADD R0,R1; HLT
    clear_prog();
    prog[0] = 16'h9005; prog[1] = 16'h9403; prog[2] = 16'h1100;
    do_reset();
    model_run();
    run_to_halt(100);
    check("add.r0",     dut.regfile_inst.registers[0], 16'h0008);
    check("add.r1",     dut.regfile_inst.registers[1], 16'h0003);
    check("add.alu",    alu_result,                    16'h0008);
    check("add.zf",     dut.zero_flag,                 1'b0);
    check("add.halt",   halt,                          1'b1);
    check("add.pc",     pc_out,                        16'h0004);
    check("add.cycles", cyc,                           14);
    compare_model("add");
    pc_hold = pc_out;
    repeat (10) tick();
    check("halt.frozen_pc", pc_out,                        pc_hold);
    check("halt.frozen_r0", dut.regfile_inst.registers[0], 16'h0008);
    check("halt.stays",     halt,                          1'b1);

    // SUB to zero, JZ taken over LDI R1,1
    clear_prog();
    prog[0] = 16'h9007; prog[1] = 16'h2000; prog[2] = 16'hD004; prog[3] = 16'h9401;
    do_reset();
    model_run();
    run_to_halt(100);
    check("jz.r0",     dut.regfile_inst.registers[0], 16'h0000);
    check("jz.r1",     dut.regfile_inst.registers[1], 16'h0000);
    check("jz.zf",     dut.zero_flag,                 1'b1);
    check("jz.pc",     pc_out,                        16'h0005);
    check("jz.cycles", cyc,                           13);
    compare_model("jz");

    // ST R1,[R2] then LD R3,[R2]; dmem[0x10] preset so the store is visible
    clear_prog();
    prog[0] = 16'h9855; prog[1] = 16'h9A10; prog[2] = 16'hB600;
    prog[3] = 16'h9C00; prog[4] = 16'hAE00;
    do_reset();
    dut.dmem[16] = 16'hBEEF;
    m_dmem[16]   = 16'hBEEF;
    model_run();
    run_to_halt(100);
    check("mem.r2",     dut.regfile_inst.registers[2], 16'h0010);
    check("mem.r3",     dut.regfile_inst.registers[3], dut.regfile_inst.registers[1]);
    check("mem.dmem",   dut.dmem[16],                  16'h0000);
    check("mem.visits", mem_visits,                    2);
    check("mem.cycles", cyc,                           23);
    check("mem.pc",     pc_out,                        16'h0006);
    compare_model("mem");

    // LDI R0,0x80; SHR; SHL; SHL
    clear_prog();
    prog[0] = 16'h9080; prog[1] = 16'h8000; prog[2] = 16'h7000; prog[3] = 16'h7000;
    do_reset();
    model_run();
    repeat (8) tick();
    check("shr.r0", dut.regfile_inst.registers[0], 16'h0040);
    run_to_halt(100);
    cyc += 8;
    check("shl.r0", dut.regfile_inst.registers[0], 16'h0100);
    check("shl.zf", dut.zero_flag,                 1'b0);
    compare_model("shift");

    // Reset asserted during WRITEBACK of LDI R3,0xFF
    clear_prog();
    prog[0] = 16'h9CFF;
    do_reset();
    repeat (3) tick();
    check("wbrst.state_before", dut.ctrl_inst.state, 3'd4);
    check("wbrst.alu_before",   alu_result,          16'h00FF);
    reset = 1'b0;
    #1;
    check("wbrst.r3",    dut.regfile_inst.registers[3], 16'h0000);
    check("wbrst.pc",    pc_out,                        16'h0000);
    check("wbrst.state", dut.ctrl_inst.state,           3'd0);
    check("wbrst.alu",   alu_result,                    16'h0000);
    check("wbrst.ir",    dut.instruction_reg,           16'h0000);
    @(negedge clk);
    reset = 1'b1;
    run_to_halt(100);
    check("wbrst.restart_r3",     dut.regfile_inst.registers[3], 16'h00FF);
    check("wbrst.restart_cycles", cyc,                           6);

    // JMP 0 forever: three-cycle loop, pc 1,1,0,...
    clear_prog();
    prog[0] = 16'hC000;
    do_reset();
    bad = 0;
    for (int k = 1; k <= 500; k++) begin
      tick();
      if (halt || dut.ctrl_inst.state > 3'd2 || pc_out != ((k % 3 == 0) ? 16'h0000 : 16'h0001))
        bad++;
    end
    check("loop.violations", bad,  0);
    check("loop.no_halt",    halt, 1'b0);

    // Random straight-line programs
    for (int t = 0; t < 4; t++) begin
      clear_prog();
      for (int i = 0; i < 24; i++) begin
        idx = $urandom_range(0, 12);
        op  = (idx == 12) ? 4'hF : 4'(idx);
        prog[i] = {op, 12'($urandom)};
      end
      do_reset();
      model_run();
      run_to_halt(400);
      compare_model($sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
